// File: rtl/vita_tx_sequencer.sv
// vita_tx_sequencer: gates timed TX bursts from the sample FIFO into the DSP chain and reports EOB/late/underrun/seqerr events
//   dac_clk, reset, clear             : clock, sync active-high reset, soft clear (keeps policy)
//   set_stb, set_addr, set_data       : settings bus; at BASE bit0=policy_next_burst, bit1=err_halt
//   vita_time                         : current VITA time
//   sample_fifo_i, src_rdy_i, dst_rdy_o : FIFO line and handshake
//   strobe, sample_o, run             : DSP sample request, sample vector, burst active
//   err_stb, err_code, err_seqnum, err_time : event strobe and its registered details
//   debug                             : {state, run, strobe, src_rdy_i, dst_rdy_o, err_stb, 24'd0}
module vita_tx_sequencer #(
  parameter int BASE = 0,
  parameter int MAXCHAN = 1
) (
  input  logic                       dac_clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [63:0]                vita_time,
  input  logic [85+32*MAXCHAN-1:0]   sample_fifo_i,
  input  logic                       src_rdy_i,
  output logic                       dst_rdy_o,
  input  logic                       strobe,
  output logic [32*MAXCHAN-1:0]      sample_o,
  output logic                       run,
  output logic                       err_stb,
  output logic [31:0]                err_code,
  output logic [3:0]                 err_seqnum,
  output logic [63:0]                err_time,
  output logic [31:0]                debug
);
  localparam int FW = 85 + 32 * MAXCHAN;
  typedef enum logic [2:0] {IDLE, RUN, REPORT, DUMP, HALT} state_t;
  state_t state, state_next;
  logic policy_next_burst, err_halt;
  logic [31:0] code_next;
  logic [3:0] last_seq;
  logic consume, late, now, unused_bits;
  logic seqerr, send_at, eob, eop;
  logic [3:0] seq;
  logic [63:0] line_time;
  logic [32*MAXCHAN-1:0] samples;
  assign samples = sample_fifo_i[FW-1:85];
  assign seqerr = sample_fifo_i[84];
  assign send_at = sample_fifo_i[83];
  assign eob = sample_fifo_i[81];
  assign eop = sample_fifo_i[80];
  assign seq = sample_fifo_i[67:64];
  assign line_time = sample_fifo_i[63:0];
  assign unused_bits = &{1'b0, sample_fifo_i[82], sample_fifo_i[79:68], set_data[31:2]};
  assign late = send_at & (vita_time > line_time);
  assign now = ~send_at | (vita_time == line_time);
  assign consume = src_rdy_i & dst_rdy_o;
  assign run = state == RUN;
  assign err_stb = state == REPORT;
  assign debug = {state, run, strobe, src_rdy_i, dst_rdy_o, err_stb, 24'd0};
  always_comb begin
    state_next = state;
    code_next = 32'd0;
    dst_rdy_o = 1'b0;
    case (state)
      IDLE: begin
        code_next = !src_rdy_i ? 32'd0 : seqerr ? 32'd4 : late ? 32'd8 : 32'd0;
        state_next = code_next != 32'd0 ? REPORT : (src_rdy_i && now) ? RUN : IDLE;
      end
      RUN: begin
        dst_rdy_o = strobe & ~seqerr;
        code_next = !strobe ? 32'd0 : !src_rdy_i ? 32'd2 : seqerr ? 32'd4 : (eop && eob) ? 32'd1 : 32'd0;
        state_next = code_next != 32'd0 ? REPORT : RUN;
      end
      REPORT: state_next = err_code == 32'd1 ? IDLE : err_halt ? HALT : DUMP;
      DUMP: begin
        dst_rdy_o = 1'b1;
        state_next = (src_rdy_i && eop && (eob || !policy_next_burst)) ? IDLE : DUMP;
      end
      HALT: state_next = err_halt ? HALT : DUMP;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge dac_clk)
    if (reset) {err_halt, policy_next_burst} <= 2'b00;
    else if (set_stb && set_addr == 8'(BASE)) {err_halt, policy_next_burst} <= set_data[1:0];
  // The final eob sample is still delivered on its strobe; sample_o zeroes on the following edge.
  always_ff @(posedge dac_clk)
    if (reset || clear) begin
      state <= IDLE;
      sample_o <= '0;
      err_code <= '0;
      err_seqnum <= '0;
      err_time <= '0;
      last_seq <= '0;
    end else begin
      state <= state_next;
      sample_o <= (state == RUN && consume) ? samples : (state == RUN && state_next == RUN) ? sample_o : '0;
      if (consume) last_seq <= seq;
      if (state_next == REPORT) begin
        err_code <= code_next;
        err_seqnum <= code_next == 32'd2 ? last_seq : seq;
        err_time <= vita_time;
      end
    end
endmodule
